// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator with
// delayed sync/enable, line/frame strobes and a frame counter.
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW1     = CNT_W + 1;

  localparam logic [CNT_W:0] H_LAST = CW1'(H_TOTAL - 1);
  localparam logic [CNT_W:0] V_LAST = CW1'(V_TOTAL - 1);
  localparam logic [CNT_W:0] H_DE   = CW1'(H_ACTIVE);
  localparam logic [CNT_W:0] V_DE   = CW1'(V_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG = CW1'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_BEG = CW1'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END = CW1'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 2**CNT_W");
  end
  if (PIPE_DEPTH < 0 || PIPE_DEPTH > 7) begin : g_bad_pipe
    $error("vga_sync_gen: PIPE_DEPTH must be 0..7");
  end

  logic [CNT_W:0] x_w;
  logic [CNT_W:0] y_w;
  logic           wrap_x;
  logic           wrap_y;
  logic           hs_raw;
  logic           vs_raw;
  logic           de_raw;
  logic           hs_pol;
  logic           vs_pol;

  // raw decode of the current position, widened so bounds never overflow
  always_comb begin
    x_w    = {1'b0, x};
    y_w    = {1'b0, y};
    wrap_x = (x_w == H_LAST);
    wrap_y = (y_w == V_LAST);
    hs_raw = (x_w >= HS_BEG) && (x_w < HS_END);
    vs_raw = (y_w >= VS_BEG) && (y_w < VS_END);
    de_raw = (x_w < H_DE) && (y_w < V_DE);
    hs_pol = hs_raw ^ ~HSYNC_POL;
    vs_pol = vs_raw ^ ~VSYNC_POL;
  end

  // pixel/line/frame counters, advancing only when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (ena) begin
      if (wrap_x) begin
        x <= '0;
        if (wrap_y) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // one-cycle strobes; they self-clear even while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= ena && wrap_x;
      frame_start <= ena && wrap_x && wrap_y;
    end
  end

  if (PIPE_DEPTH == 0) begin : g_comb
    assign hsync      = hs_pol;
    assign vsync      = vs_pol;
    assign display_on = de_raw;
  end else begin : g_pipe
    logic [PIPE_DEPTH-1:0] hs_q;
    logic [PIPE_DEPTH-1:0] vs_q;
    logic [PIPE_DEPTH-1:0] de_q;

    // delay line keeping sync/enable aligned with the pixel pipeline
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hs_q <= {PIPE_DEPTH{~HSYNC_POL}};
        vs_q <= {PIPE_DEPTH{~VSYNC_POL}};
        de_q <= '0;
      end else if (ena) begin
        hs_q[0] <= hs_pol;
        vs_q[0] <= vs_pol;
        de_q[0] <= de_raw;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          hs_q[i] <= hs_q[i-1];
          vs_q[i] <= vs_q[i-1];
          de_q[i] <= de_q[i-1];
        end
      end
    end

    assign hsync      = hs_q[PIPE_DEPTH-1];
    assign vsync      = vs_q[PIPE_DEPTH-1];
    assign display_on = de_q[PIPE_DEPTH-1];
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks two configurations of vga_sync_gen
// against a position-count reference model.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;

  logic [3:0] x0, y0;
  logic       hs0, vs0, de0, ls0, fs0;
  logic [7:0] fc0;

  logic [4:0] x1, y1;
  logic       hs1, vs1, de1, ls1, fs1;
  logic [3:0] fc1;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  logic ls_exp = 1'b0;
  logic fs_exp = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .PIPE_DEPTH(2), .CNT_W(4), .FRAME_W(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .x(x0), .y(y0),
    .hsync(hs0), .vsync(vs0), .display_on(de0),
    .line_start(ls0), .frame_start(fs0),
    .frame_cnt(fc0)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .PIPE_DEPTH(0), .CNT_W(5), .FRAME_W(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .x(x1), .y(y1),
    .hsync(hs1), .vsync(vs1), .display_on(de1),
    .line_start(ls1), .frame_start(fs1),
    .frame_cnt(fc1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h n=%0d t=%0t",
               tag, got, exp, n, $time);
    end
  endtask

  // pixel position p counts enabled cycles since reset
  function automatic int px(int p); return p % 16; endfunction
  function automatic int py(int p); return (p / 16) % 8; endfunction

  function automatic logic in_hs(int p);
    return px(p) >= 10 && px(p) < 13;
  endfunction
  function automatic logic in_vs(int p);
    return py(p) >= 5 && py(p) < 7;
  endfunction
  function automatic logic in_de(int p);
    return px(p) < 8 && py(p) < 4;
  endfunction

  task automatic check_all();
    logic e_hs0, e_vs0, e_de0;
    if (n >= 2) begin
      e_hs0 = ~in_hs(n - 2);
      e_vs0 = ~in_vs(n - 2);
      e_de0 = in_de(n - 2);
    end else begin
      e_hs0 = 1'b1;
      e_vs0 = 1'b1;
      e_de0 = 1'b0;
    end
    chk("x0", x0, px(n));
    chk("y0", y0, py(n));
    chk("fc0", fc0, (n / 128) % 256);
    chk("hs0", hs0, e_hs0);
    chk("vs0", vs0, e_vs0);
    chk("de0", de0, e_de0);
    chk("ls0", ls0, ls_exp);
    chk("fs0", fs0, fs_exp);
    chk("x1", x1, px(n));
    chk("y1", y1, py(n));
    chk("fc1", fc1, (n / 128) % 16);
    chk("hs1", hs1, in_hs(n));
    chk("vs1", vs1, in_vs(n));
    chk("de1", de1, in_de(n));
    chk("ls1", ls1, ls_exp);
    chk("fs1", fs1, fs_exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x0"}, x0, 0);
    chk({tag, "_y0"}, y0, 0);
    chk({tag, "_fc0"}, fc0, 0);
    chk({tag, "_hs0"}, hs0, 1);
    chk({tag, "_vs0"}, vs0, 1);
    chk({tag, "_de0"}, de0, 0);
    chk({tag, "_ls0"}, ls0, 0);
    chk({tag, "_fs0"}, fs0, 0);
    chk({tag, "_x1"}, x1, 0);
    chk({tag, "_y1"}, y1, 0);
    chk({tag, "_fc1"}, fc1, 0);
    chk({tag, "_hs1"}, hs1, 0);
    chk({tag, "_vs1"}, vs1, 0);
    chk({tag, "_ls1"}, ls1, 0);
    chk({tag, "_fs1"}, fs1, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (ena) begin
      n++;
      ls_exp = (n % 16 == 0);
      fs_exp = (n % 128 == 0);
    end else begin
      ls_exp = 1'b0;
      fs_exp = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    #7;
    chk_reset("rst");
    #5 rst_n = 1'b1;

    repeat (16) tick();
    chk("line1_y", y0, 1);
    chk("line1_ls", ls0, 1);
    tick();
    chk("line1_ls_clr", ls0, 0);

    while (n < 128) tick();
    chk("frame1_fc", fc0, 1);
    chk("frame1_fs", fs0, 1);

    while (n % 16 != 7) tick();
    ena = 1'b0;
    repeat (5) tick();
    chk("hold_x", x0, 7);
    ena = 1'b1;
    tick();
    chk("resume_x", x0, 8);

    while (!ls_exp) tick();
    ena = 1'b0;
    tick();
    chk("ls_clr_noena", ls0, 0);
    ena = 1'b1;

    repeat (600) begin
      ena = ($urandom_range(0, 9) != 0);
      tick();
    end
    ena = 1'b1;

    while (n % 128 != 57) tick();
    chk("mid_y", y0, 3);
    chk("mid_x", x0, 9);
    #1 rst_n = 1'b0;
    #1;
    chk_reset("async");
    n      = 0;
    ls_exp = 1'b0;
    fs_exp = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("restart_x", x0, 1);

    while (n < 255 * 128) begin
      ena = ($urandom_range(0, 15) != 0);
      tick();
    end
    ena = 1'b1;
    chk("fc_255", fc0, 255);
    repeat (128) tick();
    chk("fc_wrap", fc0, 0);
    chk("fs_wrap", fs0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VGA timing generator for the Perlin-noise display pipeline. It produces pixel/line counters, sync pulses and a display-enable for any resolution and sync polarity. Sync and display-enable outputs pass through a configurable delay so they stay aligned with a multi-stage pixel pipeline. It replaces the fixed 640x480 sync logic inside the `tt_um_*` top and adds a clock-enable, line/frame strobes and a frame counter that drives animation.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line (>=1)
- `H_FP`, 16: horizontal front porch (>=0)
- `H_SYNC`, 96: hsync width (>=1)
- `H_BP`, 48: horizontal back porch (>=0)
- `V_ACTIVE`, 480: visible lines (>=1)
- `V_FP`, 10: vertical front porch (>=0)
- `V_SYNC`, 2: vsync width (>=1)
- `V_BP`, 33: vertical back porch (>=0)
- `HSYNC_POL`, 0: hsync active level (0 = active-low)
- `VSYNC_POL`, 0: vsync active level (0 = active-low)
- `PIPE_DEPTH`, 2: delay stages on hsync/vsync/display_on (0..7)
- `CNT_W`, 10: counter width; H_TOTAL and V_TOTAL must each be <= 2^CNT_W (elaboration error otherwise)
- `FRAME_W`, 8: frame counter width

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `ena`  in  1  advance enable; when low, all state holds
- `x`  out  CNT_W  current pixel column (undelayed)
- `y`  out  CNT_W  current line (undelayed)
- `hsync`  out  1  horizontal sync, delayed PIPE_DEPTH
- `vsync`  out  1  vertical sync, delayed PIPE_DEPTH
- `display_on`  out  1  visible-area flag, delayed PIPE_DEPTH
- `line_start`  out  1  one-cycle pulse, first cycle of x==0 after a line wrap
- `frame_start`  out  1  one-cycle pulse, first cycle of x==0,y==0 after a frame wrap
- `frame_cnt`  out  FRAME_W  completed-frame count, wraps mod 2^FRAME_W

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the same sum of the V_* parameters.
- Reset (async assert; release takes effect on the next clk edge):
  - x=0, y=0, frame_cnt=0
  - line_start=0, frame_start=0, display_on=0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL (inactive)
  - every pipeline stage holds these inactive values
- Each edge with ena=1:
  - x increments. When x==H_TOTAL-1, x goes to 0 and y increments.
  - When y==V_TOTAL-1 at that same wrap, y goes to 0 and frame_cnt increments.
- Raw decode from the current x,y (combinational):
  - hs_raw: H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC
  - vs_raw: V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (whole lines)
  - de_raw: x<H_ACTIVE && y<V_ACTIVE
- Polarity is applied before the pipeline.
- Pipeline: PIPE_DEPTH register stages. They shift only when ena=1. PIPE_DEPTH=0 means the outputs are the raw decode, combinationally.
- line_start is a register:
  - set on the edge where x wraps H_TOTAL-1 -> 0
  - cleared on the next edge, regardless of ena
  - frame_start follows the same rule, set only when y also wraps to 0
  - no pulse follows reset release
- ena=0: x, y, frame_cnt and the pipeline hold. Pending strobes still clear after one cycle.
- Counter arithmetic is unsigned CNT_W. Comparisons are done at CNT_W+1 bits so no bound overflows.

## Timing
- x/y update one edge after ena=1 is sampled.
- hsync/vsync/display_on reflect the decode of the (x,y) that existed PIPE_DEPTH enabled cycles earlier.
- Strobes are high during the first cycle in which the new x==0 is visible on `x`. Aligned with undelayed x/y.
- frame_cnt updates on the same edge that raises frame_start.
- Reset mid-frame: all outputs go to reset values immediately (async). Counting restarts at x=0,y=0 on the first enabled edge after release.
- Simultaneous frame wrap and ena drop: the wrap completes on that edge only if ena=1 was sampled.

## Test plan
Small config for all scenarios: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), PIPE_DEPTH=2, ena=1 unless stated.
- Reset then 16 clocks -> x counts 0..15 then 0. y=1 after clock 16. line_start high exactly 1 cycle at x==0. No strobe right after reset.
- Full frame of 128 clocks:
  - frame_start pulses once with x=0,y=0
  - frame_cnt 0->1
  - vsync low (active-low) for lines 5-6 (32 clocks)
- Pipeline alignment, PIPE_DEPTH=2:
  - hsync low for 3 clocks starting when x==12 (raw x 10..12, delayed 2)
  - display_on high for 8 clocks starting when x==2 on lines 0-3
  - display_on low on lines 4-7
- Polarity and depth: HSYNC_POL=1, PIPE_DEPTH=0 -> hsync is high and combinational exactly while x in 10..12. Idle level is 0 after reset.
- ena gating: drop ena for 5 cycles at x=7 -> x, pipeline and frame_cnt frozen, then resume at x=8. Drop ena at the x=0 strobe cycle -> line_start still clears after 1 cycle.
- Reset mid-frame at y=3,x=9 -> all outputs take reset values asynchronously, before the next edge. Resume from 0,0. frame_cnt returns to 0. frame_cnt wraps 255->0 after 256 frames (FRAME_W=8).
